// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART receive frame parser: state encoding,
// abort reason codes and byte-fetch pacing.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CSUM = 3'd2;
    localparam logic [2:0] ERR_LINE = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;
    localparam logic [2:0] ERR_OVF  = 3'd5;

    localparam int unsigned GUARD_CYC = 3;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload store for one frame: synchronous write, combinational read.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             CLK,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser draining the UART receive register: hunts SOF, checks length
// and checksum, buffers the payload and streams it out with valid/ready.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SOF         = 8'h7E,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RXRDY,
    input  logic [7:0] UART_DATA,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    input  logic       OVERFLOW,
    output logic       CSN,
    output logic       OEN,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int unsigned PTR_W   = ptr_width(MAX_LEN);
    localparam int unsigned GUARD_W = $clog2(GUARD_CYC + 1);
    localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t             state, state_nxt;
    logic               rd_stb;
    logic [GUARD_W-1:0] guard_cnt;
    logic               fetch_go;
    logic               fetch_state, mid_state;
    logic               line_err;
    logic [31:0]        tmo_cnt;
    logic               tmo_hit;
    logic [7:0]         acc, acc_nxt;
    logic [7:0]         sum;
    logic [7:0]         cnt, cnt_nxt;
    logic [7:0]         len_q, len_nxt;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
    logic               buf_we;
    logic [7:0]         buf_rd_data;
    logic               out_en, out_en_nxt;
    logic               ok_nxt, ferr_nxt;
    logic [2:0]         code_nxt;

    assign fetch_state = (state != ST_DRAIN);
    assign mid_state   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign line_err    = PARITY_ERR | FRAMING_ERR;
    assign sum         = acc + UART_DATA;

    // Strobe is registered; guard loaded on the strobe cycle gives a 4-cycle fetch period.
    assign fetch_go = fetch_state && RXRDY && !rd_stb && (guard_cnt == '0);
    assign CSN      = !rd_stb;
    assign OEN      = !rd_stb;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_stb    <= 1'b0;
            guard_cnt <= '0;
        end else begin
            rd_stb <= fetch_go;
            if (fetch_go) begin
                guard_cnt <= GUARD_W'(GUARD_CYC);
            end else if (guard_cnt != '0) begin
                guard_cnt <= guard_cnt - GUARD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt <= '0;
        end else if (rd_stb || !mid_state) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_hit = (TIMEOUT_CYC != 0) && mid_state && (tmo_cnt == TMO_LAST);

    assign m_valid = (state == ST_DRAIN) && out_en;
    assign m_last  = m_valid && (8'(rd_ptr) == (len_q - 8'd1));
    assign m_data  = m_valid ? buf_rd_data : '0;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        len_nxt    = len_q;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        buf_we     = 1'b0;
        out_en_nxt = 1'b0;
        ok_nxt     = 1'b0;
        ferr_nxt   = 1'b0;
        code_nxt   = err_code;

        case (state)
            ST_HUNT: begin
                if (rd_stb && !line_err && (UART_DATA == SOF)) begin
                    state_nxt  = ST_LEN;
                    acc_nxt    = '0;
                    wr_ptr_nxt = '0;
                    rd_ptr_nxt = '0;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (rd_stb) begin
                    if (line_err) begin
                        state_nxt = ST_HUNT;
                        ferr_nxt  = 1'b1;
                        code_nxt  = ERR_LINE;
                    end else if (OVERFLOW) begin
                        state_nxt = ST_HUNT;
                        ferr_nxt  = 1'b1;
                        code_nxt  = ERR_OVF;
                    end else if (state == ST_LEN) begin
                        if ((UART_DATA == 8'd0) || (UART_DATA > LEN_MAX)) begin
                            state_nxt = ST_HUNT;
                            ferr_nxt  = 1'b1;
                            code_nxt  = ERR_LEN;
                        end else begin
                            state_nxt = ST_PAYLOAD;
                            acc_nxt   = sum;
                            cnt_nxt   = UART_DATA;
                            len_nxt   = UART_DATA;
                        end
                    end else if (state == ST_PAYLOAD) begin
                        buf_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        acc_nxt    = sum;
                        cnt_nxt    = cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state_nxt = ST_CHK;
                        end
                    end else begin
                        if (sum == 8'd0) begin
                            state_nxt = ST_DRAIN;
                            ok_nxt    = 1'b1;
                        end else begin
                            state_nxt = ST_HUNT;
                            ferr_nxt  = 1'b1;
                            code_nxt  = ERR_CSUM;
                        end
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_HUNT;
                    ferr_nxt  = 1'b1;
                    code_nxt  = ERR_TMO;
                end
            end
            ST_DRAIN: begin
                out_en_nxt = 1'b1;
                if (m_valid && m_ready) begin
                    rd_ptr_nxt = rd_ptr + PTR_W'(1);
                    if (m_last) begin
                        state_nxt  = ST_HUNT;
                        out_en_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_HUNT;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_en    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            len_q     <= len_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            out_en    <= out_en_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= ferr_nxt;
            err_code  <= code_nxt;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .PTR_W (PTR_W)
    ) u_buf (
        .CLK     (CLK),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr),
        .wr_data (UART_DATA),
        .rd_addr (rd_ptr),
        .rd_data (buf_rd_data)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: emulates the UART read handshake and
// checks frame acceptance, abort codes, drain timing and reset behaviour.
module tb_uart_frame_rx;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       RXRDY = 1'b0;
    logic [7:0] UART_DATA = 8'h00;
    logic       PARITY_ERR = 1'b0;
    logic       FRAMING_ERR = 1'b0;
    logic       OVERFLOW = 1'b0;
    logic       CSN, OEN;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       frame_ok, frame_err;
    logic [2:0] err_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sample_cyc = 0;
    int ok_cnt = 0, ok_cyc = 0;
    int err_cnt = 0, err_cyc = 0;
    logic [2:0] last_code = 3'd0;
    int stb_cnt = 0;

    logic [7:0] q_d[$];
    logic       q_l[$];
    int         q_c[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    uart_frame_rx #(
        .MAX_LEN     (16),
        .SOF         (8'h7E),
        .TIMEOUT_CYC (50)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .RXRDY       (RXRDY),
        .UART_DATA   (UART_DATA),
        .PARITY_ERR  (PARITY_ERR),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERFLOW    (OVERFLOW),
        .CSN         (CSN),
        .OEN         (OEN),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (m_valid && m_ready) begin
            q_d.push_back(m_data);
            q_l.push_back(m_last);
            q_c.push_back(cyc);
        end
        if (frame_ok) begin
            ok_cnt <= ok_cnt + 1;
            ok_cyc <= cyc;
        end
        if (frame_err) begin
            err_cnt   <= err_cnt + 1;
            err_cyc   <= cyc;
            last_code <= err_code;
        end
        if (!CSN) stb_cnt <= stb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic ov);
        bit seen = 0;
        UART_DATA  = d;
        PARITY_ERR = pe;
        OVERFLOW   = ov;
        RXRDY      = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            if (!CSN && !OEN) seen = 1;
        end
        if (!seen) begin
            check("strobe_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge CLK);
        end
        #1;
        sample_cyc = cyc;
        RXRDY      = 1'b0;
        PARITY_ERR = 1'b0;
        OVERFLOW   = 1'b0;
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0, 1'b0);
    endtask

    task automatic cmp_out(input string tag, input int base, input bit contig);
        check({tag, "_n"}, 32'(q_d.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < q_d.size()) begin
                check($sformatf("%s_d%0d", tag, i), 32'(q_d[base+i]), 32'(exp_q[i]));
                check($sformatf("%s_l%0d", tag, i), 32'(q_l[base+i]), 32'(i == exp_q.size() - 1));
                if (contig && i > 0)
                    check($sformatf("%s_c%0d", tag, i), 32'(q_c[base+i] - q_c[base+i-1]), 32'd1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int base, e0, o0, s0, st0, prev_s;
        logic pv, pr, pl;
        logic [7:0] pd;

        idle(3);
        check("rst_csn", 32'(CSN), 32'd1);
        check("rst_oen", 32'(OEN), 32'd1);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_ok", 32'(frame_ok), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        RESET_N = 1'b1;
        idle(2);

        // 03+11+22+33 = 69, so the checksum byte is 97
        base = q_d.size(); o0 = ok_cnt; e0 = err_cnt;
        send_byte(8'h7E, 1'b0, 1'b0);
        prev_s = sample_cyc;
        send_byte(8'h03, 1'b0, 1'b0);
        check("fetch_period", 32'(sample_cyc - prev_s), 32'd4);
        tx_q = {8'h11, 8'h22, 8'h33, 8'h97};
        send_all();
        s0 = sample_cyc;
        idle(8);
        check("f1_ok", 32'(ok_cnt - o0), 32'd1);
        check("f1_ok_cyc", 32'(ok_cyc - s0), 32'd0);
        check("f1_err", 32'(err_cnt - e0), 32'd0);
        exp_q = {8'h11, 8'h22, 8'h33};
        cmp_out("f1", base, 1'b1);
        if (q_d.size() > base) check("f1_first", 32'(q_c[base] - ok_cyc), 32'd1);

        base = q_d.size(); o0 = ok_cnt; e0 = err_cnt;
        tx_q = {8'h55, 8'hAA, 8'h7E, 8'h01, 8'h42, 8'hBD};
        send_all();
        idle(6);
        check("f2_ok", 32'(ok_cnt - o0), 32'd1);
        check("f2_noerr", 32'(err_cnt - e0), 32'd0);
        exp_q = {8'h42};
        cmp_out("f2", base, 1'b0);

        base = q_d.size(); o0 = ok_cnt; e0 = err_cnt;
        tx_q = {8'h7E, 8'h02, 8'h10, 8'h20, 8'h00};
        send_all();
        idle(6);
        check("csum_err", 32'(err_cnt - e0), 32'd1);
        check("csum_code", 32'(last_code), 32'd2);
        check("csum_nout", 32'(q_d.size() - base), 32'd0);
        tx_q = {8'h7E, 8'h02, 8'h05, 8'h06, 8'hF3};
        send_all();
        idle(6);
        check("f3_ok", 32'(ok_cnt - o0), 32'd1);
        exp_q = {8'h05, 8'h06};
        cmp_out("f3", base, 1'b1);

        e0 = err_cnt;
        tx_q = {8'h7E, 8'h00};
        send_all();
        idle(3);
        check("len0_err", 32'(err_cnt - e0), 32'd1);
        check("len0_code", 32'(last_code), 32'd1);
        e0 = err_cnt;
        tx_q = {8'h7E, 8'h11};
        send_all();
        idle(3);
        check("len17_err", 32'(err_cnt - e0), 32'd1);
        check("len17_code", 32'(last_code), 32'd1);

        // Full-size frame: 10 + (1+..+16) = 98, checksum 68
        base = q_d.size(); o0 = ok_cnt;
        tx_q = {8'h7E, 8'h10};
        exp_q = {};
        for (int i = 1; i <= 16; i++) begin
            tx_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        tx_q.push_back(8'h68);
        send_all();
        idle(22);
        check("f16_ok", 32'(ok_cnt - o0), 32'd1);
        cmp_out("f16", base, 1'b1);

        e0 = err_cnt;
        send_byte(8'h7E, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        idle(3);
        check("par_err", 32'(err_cnt - e0), 32'd1);
        check("par_code", 32'(last_code), 32'd3);

        e0 = err_cnt;
        send_byte(8'h7E, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        idle(3);
        check("ovf_err", 32'(err_cnt - e0), 32'd1);
        check("ovf_code", 32'(last_code), 32'd5);

        e0 = err_cnt;
        send_byte(8'h7E, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        s0 = sample_cyc;
        idle(60);
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        check("tmo_code", 32'(last_code), 32'd4);
        check("tmo_cyc", 32'(err_cyc - s0), 32'd50);
        check("code_hold", 32'(err_code), 32'd4);

        // 03+A1+B2+C3 = 19, checksum E7; drain with m_ready toggling
        base = q_d.size(); o0 = ok_cnt;
        m_ready = 1'b0;
        tx_q = {8'h7E, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE7};
        send_all();
        pv = 1'b0; pr = 1'b0; pd = 8'h00; pl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (pv && !pr) begin
                check("hold_v", 32'(m_valid), 32'd1);
                check("hold_d", 32'(m_data), 32'(pd));
                check("hold_l", 32'(m_last), 32'(pl));
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            @(posedge CLK);
            #1 m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        idle(2);
        check("stall_ok", 32'(ok_cnt - o0), 32'd1);
        exp_q = {8'hA1, 8'hB2, 8'hC3};
        cmp_out("stall", base, 1'b0);
        check("code_hold2", 32'(err_code), 32'd4);

        e0 = err_cnt;
        m_ready = 1'b0;
        tx_q = {8'h7E, 8'h01, 8'h42, 8'hBD};
        send_all();
        idle(2);
        UART_DATA = 8'h7E;
        RXRDY = 1'b1;
        st0 = stb_cnt;
        idle(8);
        check("drain_nostb", 32'(stb_cnt - st0), 32'd0);
        check("drain_valid", 32'(m_valid), 32'd1);
        check("drain_data", 32'(m_data), 32'h42);
        #2 RESET_N = 1'b0;
        #1;
        check("rstd_valid", 32'(m_valid), 32'd0);
        check("rstd_csn", 32'(CSN), 32'd1);
        check("rstd_oen", 32'(OEN), 32'd1);
        check("rstd_data", 32'(m_data), 32'd0);
        RXRDY = 1'b0;
        idle(3);
        RESET_N = 1'b1;
        idle(2);
        check("rstd_noerr", 32'(err_cnt - e0), 32'd0);
        check("rstd_code", 32'(err_code), 32'd0);

        base = q_d.size();
        m_ready = 1'b1;
        send_all();
        idle(6);
        exp_q = {8'h42};
        cmp_out("post_rst", base, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
